// File: rtl/cfu_seq_pkg.sv
// Shared types and constants for the CFU command sequencer and its response FIFO.
package cfu_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_STATUS    = 2'd3
  } seq_state_e;

  // Opcode that reports the retired-response count instead of touching the backend.
  localparam int unsigned OP_STATUS = 0;

  // Value returned to the CPU when a write-class operation is acknowledged.
  localparam int unsigned WR_ACK_VALUE = 0;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a depth-entry ring; at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cfu_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count and a combinational head.
// Push and pop may happen in the same cycle; the head is held until popped.
module cfu_rsp_fifo
  import cfu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic                          valid_o,
  output logic [DATA_W-1:0]             head_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              not_empty;
  logic              do_push;
  logic              do_pop;

  // Ring pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign not_empty = (count_q != '0);
  assign do_pop    = pop_i && not_empty;
  // A push into a full FIFO is only honoured when a pop frees the slot this cycle.
  assign do_push   = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = not_empty;
  // Forced to zero when empty so the response bus idles at a known value.
  assign head_o  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/cfu_cmd_sequencer.sv
// CFU front-end: registers CPU commands, issues them one at a time to the TPU
// backend over ready/valid, waits for read data where needed, and returns
// responses in order through a small FIFO that absorbs CPU back-pressure.
module cfu_cmd_sequencer
  import cfu_seq_pkg::*;
#(
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           FUNCT_W   = 10,
  parameter int unsigned           OP_W      = 3,
  parameter logic [2**OP_W-1:0]    READ_MASK = 8'b1000_1000,
  parameter int unsigned           RSP_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  // CPU command channel
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [FUNCT_W-1:0]  cmd_payload_function_id,
  input  logic [DATA_W-1:0]   cmd_payload_inputs_0,
  input  logic [DATA_W-1:0]   cmd_payload_inputs_1,
  // CPU response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_payload_outputs_0,
  // Backend issue channel
  output logic                be_valid,
  input  logic                be_ready,
  output logic [OP_W-1:0]     be_op,
  output logic [DATA_W-1:0]   be_in0,
  output logic [DATA_W-1:0]   be_in1,
  // Backend read return
  input  logic                be_rdata_valid,
  input  logic [DATA_W-1:0]   be_rdata,
  output logic                busy
);

  localparam int unsigned CNT_W = cnt_width(RSP_DEPTH);

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] in0_q, in0_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] retired_cnt_q, retired_cnt_d;

  logic              accept;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [OP_W-1:0]   cmd_op;

  assign cmd_op = cmd_payload_function_id[OP_W-1:0];

  // Upper function_id bits carry no meaning for this block.
  generate
    if (FUNCT_W > OP_W) begin : g_fid_hi
      logic unused_fid_hi;
      assign unused_fid_hi = ^cmd_payload_function_id[FUNCT_W-1:OP_W];
    end
  endgenerate

  // Accept only from IDLE and only when a response slot is guaranteed free,
  // so every accepted command can always push its response. Held low while
  // reset is asserted.
  assign cmd_ready = rst_n && (state_q == ST_IDLE) && (fifo_count < CNT_W'(RSP_DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = fifo_valid && rsp_ready;

  // Next-state, command latch and FIFO push decisions.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          in0_d   = cmd_payload_inputs_0;
          in1_d   = cmd_payload_inputs_1;
          state_d = (cmd_op == OP_W'(OP_STATUS)) ? ST_STATUS : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (be_ready) begin
          if (READ_MASK[op_q]) begin
            state_d = ST_WAIT_DATA;
          end else begin
            push      = 1'b1;
            push_data = DATA_W'(WR_ACK_VALUE);
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (be_rdata_valid) begin
          push      = 1'b1;
          push_data = be_rdata;
          state_d   = ST_IDLE;
        end
      end
      ST_STATUS: begin
        push      = 1'b1;
        push_data = retired_cnt_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Retired count advances on each response the CPU consumes, wrapping naturally.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (pop) begin
      retired_cnt_d = retired_cnt_q + DATA_W'(1);
    end
  end

  // State, latched command and retire counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      in0_q         <= '0;
      in1_q         <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      in0_q         <= in0_d;
      in1_q         <= in1_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  cfu_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign rsp_valid             = fifo_valid;
  assign rsp_payload_outputs_0 = fifo_head;

  assign be_valid = (state_q == ST_ISSUE);
  assign be_op    = op_q;
  assign be_in0   = in0_q;
  assign be_in1   = in1_q;

  assign busy = (state_q != ST_IDLE) || fifo_valid;

endmodule
